// File: rtl/alu_driver.sv
// ---------------------------------------------------------------------------
// alu_driver
// Sequences one command at a time into an external multi-cycle ALU and
// returns its result over a valid/ready response channel.
//
// Parameters
//   WIDTH    operand/result width (default 8)
//   ALU_LAT  cycles from operand issue to valid ALU result, 1..15 (default 2)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_a, cmd_b        opcode (0 and,1 or,2 not,3 xor,4 add,5 sub,
//                               6 mult,7 clear) and operands
//   cmd_chain                   use ALU accumulator instead of cmd_a
//   in_selector                 one-hot to ALU: 100 persist, 010 load, 001 reset
//   out_selector                one-hot ALU function, bit index = cmd_op
//   num1, num2                  operands to ALU
//   alu_result, alu_overflow    from ALU
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_error         sampled result and overflow flag
//
// Build option
//   ALU_DRIVER_CHAIN_EN  when defined, cmd_chain selects the accumulator as
//                        first operand; when undefined, cmd_chain is ignored.
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// ISSUE | one cycle driving operands/selectors to the ALU
// WAIT  | ALU_LAT-1 cycles counting down; result sampled on the last one
// RESP  | rsp_valid high until rsp_ready
// ---------------------------------------------------------------------------
module alu_driver #(
   parameter int WIDTH   = 8,
   parameter int ALU_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_chain,
   output logic [2:0]       in_selector,
   output logic [6:0]       out_selector,
   output logic [WIDTH-1:0] num1,
   output logic [WIDTH-1:0] num2,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_overflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_error
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

   localparam int             CNT_W    = 4;
   // WAIT lasts ALU_LAT-1 cycles: counter loads ALU_LAT-2 and samples at zero.
   localparam logic [CNT_W-1:0] CNT_LOAD = (ALU_LAT > 1) ? CNT_W'(ALU_LAT - 2) : '0;
   localparam logic [2:0]     OP_CLEAR = 3'd7;

   stateT             state, nextState;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        opReg;
   logic [WIDTH-1:0]  aReg, bReg;
   logic [WIDTH-1:0]  lastNum2;
   logic [6:0]        lastOutSel;
   logic [WIDTH-1:0]  rspData;
   logic              rspError;

   logic              accept, doSample, isArith;
   logic [2:0]        issueInSel;
   logic [6:0]        issueOutSel;
   logic [WIDTH-1:0]  issueNum1, issueNum2;

   assign accept   = cmd_valid && cmd_ready;
   // With ALU_LAT==1 there is no WAIT state and the result is taken at the
   // end of ISSUE.
   assign doSample = ((ALU_LAT == 1) && (state == ISSUE)) ||
                     ((state == WAIT) && (cnt == '0));
   assign isArith  = (opReg == 3'd4) || (opReg == 3'd5) || (opReg == 3'd6);

`ifdef ALU_DRIVER_CHAIN_EN
   logic chainReg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chainReg <= 1'b0;
      end else if (accept) begin
         chainReg <= cmd_chain;
      end
   end
`else
   logic unusedChain;
   assign unusedChain = cmd_chain;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // next-state logic
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (cmd_valid) nextState = ISSUE;
         ISSUE:   nextState = (ALU_LAT == 1) ? RESP : WAIT;
         WAIT:    if (cnt == '0) nextState = RESP;
         RESP:    if (rsp_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // operand / selector values presented during ISSUE
   always_comb begin
      case (opReg)
         3'd0:    issueOutSel = 7'b0000001;
         3'd1:    issueOutSel = 7'b0000010;
         3'd2:    issueOutSel = 7'b0000100;
         3'd3:    issueOutSel = 7'b0001000;
         3'd4:    issueOutSel = 7'b0010000;
         3'd5:    issueOutSel = 7'b0100000;
         3'd6:    issueOutSel = 7'b1000000;
         default: issueOutSel = 7'b0000000;
      endcase
      if (opReg == OP_CLEAR) begin
         issueInSel = 3'b001;
         issueNum1  = '0;
         issueNum2  = '0;
      end else begin
         issueInSel = 3'b010;
         issueNum1  = aReg;
         issueNum2  = bReg;
`ifdef ALU_DRIVER_CHAIN_EN
         if (chainReg) begin
            issueInSel = 3'b100;
            issueNum1  = '0;
         end
`endif
      end
   end

   // datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opReg      <= '0;
         aReg       <= '0;
         bReg       <= '0;
         cnt        <= '0;
         lastNum2   <= '0;
         lastOutSel <= '0;
         rspData    <= '0;
         rspError   <= 1'b0;
      end else begin
         if (accept) begin
            opReg <= cmd_op;
            aReg  <= cmd_a;
            bReg  <= cmd_b;
         end
         if (state == ISSUE) begin
            cnt        <= CNT_LOAD;
            lastNum2   <= issueNum2;
            lastOutSel <= issueOutSel;
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         if (doSample) begin
            if (opReg == OP_CLEAR) begin
               rspData  <= '0;
               rspError <= 1'b0;
            end else begin
               rspData  <= alu_result;
               rspError <= isArith ? alu_overflow : 1'b0;
            end
         end
      end
   end

   // outputs; in_selector and cmd_ready follow rst_n directly so the ALU
   // sees a reset request for as long as the driver is held in reset
   always_comb begin
      cmd_ready    = rst_n && (state == IDLE);
      rsp_valid    = (state == RESP);
      in_selector  = 3'b100;
      out_selector = lastOutSel;
      num1         = '0;
      num2         = lastNum2;
      if (!rst_n) begin
         in_selector = 3'b001;
      end else if (state == ISSUE) begin
         in_selector  = issueInSel;
         out_selector = issueOutSel;
         num1         = issueNum1;
         num2         = issueNum2;
      end
   end

   assign rsp_data  = rspData;
   assign rsp_error = rspError;

endmodule

// File: tb/tb_alu_driver.sv
`timescale 1ns/1ps
module tb_alu_driver;
   localparam int WIDTH   = 8;
   localparam int ALU_LAT = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = '0;
   logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0;
   logic             cmd_chain = 1'b0;
   logic [2:0]       in_selector;
   logic [6:0]       out_selector;
   logic [WIDTH-1:0] num1, num2;
   logic [WIDTH-1:0] alu_result;
   logic             alu_overflow;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_error;

   alu_driver #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
      .in_selector(in_selector), .out_selector(out_selector),
      .num1(num1), .num2(num2),
      .alu_result(alu_result), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_error(rsp_error)
   );

   always #5 clk = ~clk;

   typedef struct { logic [2:0] inSel; logic [6:0] outSel; logic [7:0] n1; logic [7:0] n2; } issueExpT;
   typedef struct { logic [7:0] data; logic err; } rspExpT;

   issueExpT issueQ[$];
   rspExpT   rspQ[$];

   int testsRun = 0;
   int testsFailed = 0;
   int acceptCount = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic failNow(input string name);
      testsRun++;
      testsFailed++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // ---------------- ALU model (accumulator + one-cycle result register)
   function automatic logic [8:0] aluCalc(input logic [6:0] sel, input logic [7:0] x, input logic [7:0] y);
      logic [15:0] p;
      p = 16'(x) * 16'(y);
      case (sel)
         7'b0000001: return {1'b0, x & y};
         7'b0000010: return {1'b0, x | y};
         7'b0000100: return {1'b0, ~x};
         7'b0001000: return {1'b0, x ^ y};
         7'b0010000: return 9'(x) + 9'(y);
         7'b0100000: return {(x < y), 8'(x - y)};
         7'b1000000: return {(|p[15:8]), p[7:0]};
         default:    return 9'd0;
      endcase
   endfunction

   logic [7:0] aluRes = 8'h00;
   logic       aluOvf = 1'b0;
   logic       forceOvf = 1'b0;
   logic       isIssue;
   int         sinceAccept;
   logic       prevValid;

   assign alu_result   = aluRes;
   assign alu_overflow = aluOvf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) isIssue <= 1'b0;
      else        isIssue <= cmd_valid && cmd_ready;
   end

   always @(posedge clk) begin
      if (cmd_valid && cmd_ready) sinceAccept <= 0;
      else                        sinceAccept <= sinceAccept + 1;
      if (isIssue) begin
         if (in_selector == 3'b001) begin
            aluRes <= 8'h00;
            aluOvf <= forceOvf;
         end else if (in_selector == 3'b100) begin
            {aluOvf, aluRes} <= aluCalc(out_selector, aluRes, num2) | {forceOvf, 8'h00};
         end else begin
            {aluOvf, aluRes} <= aluCalc(out_selector, num1, num2) | {forceOvf, 8'h00};
         end
      end
   end

   // ---------------- monitor: issue cycle and response handshake
   always @(negedge clk) begin
      if (rst_n && isIssue) begin
         if (issueQ.size() == 0) failNow("issue_unexpected");
         else begin
            issueExpT e;
            e = issueQ.pop_front();
            check("issue_in_selector", 32'(in_selector), 32'(e.inSel));
            check("issue_out_selector", 32'(out_selector), 32'(e.outSel));
            check("issue_num1", 32'(num1), 32'(e.n1));
            check("issue_num2", 32'(num2), 32'(e.n2));
         end
      end
      if (rsp_valid && !prevValid) begin
         check("latency", 32'(sinceAccept), 32'(ALU_LAT));
      end
      if (rsp_valid && rsp_ready) begin
         if (rspQ.size() == 0) failNow("rsp_unexpected");
         else begin
            rspExpT r;
            r = rspQ.pop_front();
            check("rsp_data", 32'(rsp_data), 32'(r.data));
            check("rsp_error", 32'(rsp_error), 32'(r.err));
         end
      end
      prevValid <= rsp_valid;
   end

   always @(posedge clk) if (cmd_valid && cmd_ready) acceptCount <= acceptCount + 1;

   // ---------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sendCmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic chain, input logic fo,
                          input logic [2:0] eIn, input logic [6:0] eOut,
                          input logic [7:0] eN1, input logic [7:0] eN2,
                          input logic [7:0] eData, input logic eErr);
      int budget;
      issueExpT ie;
      rspExpT re;
      ie.inSel = eIn; ie.outSel = eOut; ie.n1 = eN1; ie.n2 = eN2;
      re.data = eData; re.err = eErr;
      issueQ.push_back(ie);
      rspQ.push_back(re);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain; forceOvf = fo;
      cmd_valid = 1'b1;
      budget = 0;
      while (!cmd_ready && budget < 50) begin
         tick();
         budget++;
      end
      if (!cmd_ready) failNow("accept_timeout");
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while ((rspQ.size() != 0 || !cmd_ready) && budget < 50) begin
         tick();
         budget++;
      end
      if (budget >= 50) failNow("drain_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int budget;
      // reset state
      tick();
      tick();
      check("rst_in_selector", 32'(in_selector), 32'h1);
      check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_data", 32'(rsp_data), 32'h0);
      check("rst_rsp_error", 32'(rsp_error), 32'h0);
      check("rst_out_selector", 32'(out_selector), 32'h0);
      check("rst_num1", 32'(num1), 32'h0);
      check("rst_num2", 32'(num2), 32'h0);
      rst_n = 1'b1;
      #1;
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);
      check("post_rst_in_selector", 32'(in_selector), 32'h4);
      tick();

      // add, then chained add using the accumulator (8 from the previous add)
      sendCmd(3'd4, 8'h05, 8'h03, 1'b0, 1'b0, 3'b010, 7'b0010000, 8'h05, 8'h03, 8'h08, 1'b0);
      drain();
`ifdef ALU_DRIVER_CHAIN_EN
      sendCmd(3'd4, 8'h10, 8'h02, 1'b1, 1'b0, 3'b100, 7'b0010000, 8'h00, 8'h02, 8'h0A, 1'b0);
`else
      sendCmd(3'd4, 8'h10, 8'h02, 1'b1, 1'b0, 3'b010, 7'b0010000, 8'h10, 8'h02, 8'h12, 1'b0);
`endif
      drain();
      // logic ops; and with overflow forced must still report no error
      sendCmd(3'd0, 8'hF0, 8'h3C, 1'b0, 1'b1, 3'b010, 7'b0000001, 8'hF0, 8'h3C, 8'h30, 1'b0);
      drain();
      sendCmd(3'd1, 8'h0F, 8'h30, 1'b0, 1'b0, 3'b010, 7'b0000010, 8'h0F, 8'h30, 8'h3F, 1'b0);
      drain();
      sendCmd(3'd2, 8'hA5, 8'h00, 1'b0, 1'b0, 3'b010, 7'b0000100, 8'hA5, 8'h00, 8'h5A, 1'b0);
      drain();
      sendCmd(3'd3, 8'hFF, 8'h0F, 1'b0, 1'b0, 3'b010, 7'b0001000, 8'hFF, 8'h0F, 8'hF0, 1'b0);
      drain();
      // arithmetic overflow cases
      sendCmd(3'd5, 8'h03, 8'h05, 1'b0, 1'b0, 3'b010, 7'b0100000, 8'h03, 8'h05, 8'hFE, 1'b1);
      drain();
      sendCmd(3'd4, 8'hFF, 8'h01, 1'b0, 1'b0, 3'b010, 7'b0010000, 8'hFF, 8'h01, 8'h00, 1'b1);
      drain();
      // clear with ALU overflow forced high -> data 0, error 0
      sendCmd(3'd7, 8'h55, 8'hAA, 1'b0, 1'b1, 3'b001, 7'b0000000, 8'h00, 8'h00, 8'h00, 1'b0);
      drain();

      // back-pressure: mult 0x20*0x10 held 5 cycles with a competing command
      rsp_ready = 1'b0;
      sendCmd(3'd6, 8'h20, 8'h10, 1'b0, 1'b0, 3'b010, 7'b1000000, 8'h20, 8'h10, 8'h00, 1'b1);
      budget = 0;
      while (!rsp_valid && budget < 20) begin
         tick();
         budget++;
      end
      if (!rsp_valid) failNow("stall_rsp_timeout");
      cmd_op = 3'd4; cmd_a = 8'h01; cmd_b = 8'h01; cmd_valid = 1'b1;
      begin
         int acc0;
         acc0 = acceptCount;
         for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'h1);
            check("stall_rsp_data", 32'(rsp_data), 32'h00);
            check("stall_rsp_error", 32'(rsp_error), 32'h1);
            check("stall_cmd_ready", 32'(cmd_ready), 32'h0);
            check("stall_in_selector", 32'(in_selector), 32'h4);
            check("stall_out_selector", 32'(out_selector), 32'h40);
            tick();
         end
         check("stall_no_accept", 32'(acceptCount), 32'(acc0));
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      drain();

      // reset during WAIT abandons the command
      sendCmd(3'd4, 8'h01, 8'h01, 1'b0, 1'b0, 3'b010, 7'b0010000, 8'h01, 8'h01, 8'h02, 1'b0);
      tick();
      rst_n = 1'b0;
      rspQ.delete();
      #1;
      check("midrst_in_selector", 32'(in_selector), 32'h1);
      check("midrst_cmd_ready", 32'(cmd_ready), 32'h0);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("midrst_out_selector", 32'(out_selector), 32'h0);
      check("midrst_num2", 32'(num2), 32'h0);
      tick();
      rst_n = 1'b1;
      #1;
      check("midrst_release_cmd_ready", 32'(cmd_ready), 32'h1);
      check("midrst_release_in_selector", 32'(in_selector), 32'h4);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("midrst_no_rsp", 32'(rsp_valid), 32'h0);
      end
      sendCmd(3'd4, 8'h05, 8'h03, 1'b0, 1'b0, 3'b010, 7'b0010000, 8'h05, 8'h03, 8'h08, 1'b0);
      drain();
      tick();
      tick();
      if (issueQ.size() != 0) failNow("issue_queue_not_empty");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
